pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the single-cycle/multi-cycle CPU datapath; successor to the basic PC register. It holds the current instruction address and selects the next one from sequential, PC-relative branch, absolute jump, register jump, return-address-stack pop, trap vector or exception return. It also carries a circular return-address stack (RAS) and an exception PC (EPC) register. The instruction memory and control unit sit on either side of it.

## Interface
- WIDTH, 32, address/data width in bits.
- RESET_ADDR, 0, value loaded into Address on reset.
- TRAP_ADDR, 32'h0000_0100, trap vector, WIDTH bits.
- IMM_SHIFT, 1, left shift applied to immediate for PC-relative branches (1 means ×2).
- RAS_DEPTH, 4, return-address-stack entries (≥2, power of two).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- PCWre  in  1  PC write enable; 0 means stall, which freezes Address, RAS and EPC (except trap).
- PCSrc  in  2  00 sequential, 01 branch relative, 10 jump absolute (immediate), 11 jump register (target).
- immediate  in  WIDTH  sign-extended offset (mode 01) or absolute address (mode 10).
- target  in  WIDTH  register jump address (mode 11).
- push  in  1  call: push Address+4 onto the RAS.
- pop  in  1  return: next PC is the RAS top.
- trap  in  1  exception request.
- eret  in  1  return from exception: next PC is EPC.
- Address  out  WIDTH  current PC, registered.
- PCPlus4  out  WIDTH  combinational Address+4.
- EPC  out  WIDTH  saved trapping PC, registered.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count equals RAS_DEPTH.
- ras_underflow  out  1  sticky; set by a pop on an empty RAS.

## Operation
- Next-PC priority, evaluated at each rising edge with Reset=1:
  1. trap: Address←TRAP_ADDR and EPC←Address. Acts even when PCWre=0. push, pop and eret are ignored.
  2. eret (PCWre=1): Address←EPC.
  3. pop (PCWre=1): if RAS is non-empty, Address←RAS top and count decrements. If RAS is empty, Address←Address+4 and ras_underflow←1.
  4. Otherwise (PCWre=1), by PCSrc:
     - 00: Address+4.
     - 01: Address+4+(immediate<<IMM_SHIFT).
     - 10: immediate.
     - 11: target.
- push (PCWre=1, no trap): stores Address+4, the address sampled at that edge.
  - push applies independently of the PC-select priority, but is ignored when eret=1.
  - push with pop: the pop reads the old top, then the push overwrites that same slot. Count is unchanged and the next PC is the old top.
  - push when full: circular overwrite. The oldest entry is lost, the top pointer advances, count stays RAS_DEPTH and ras_full stays 1. No error flag.
- RAS structure: circular buffer of RAS_DEPTH×WIDTH with a top pointer (log2 RAS_DEPTH bits) and count (0..RAS_DEPTH).
- Arithmetic: all additions are modulo 2^WIDTH. Wrap-around past all-ones is silent, e.g. Address=FFFF_FFFC in mode 00 gives 0000_0000. The shift discards the high bits.
- Reset (Reset=0 at an edge): Address←RESET_ADDR, EPC←0, count←0, top←0, ras_underflow←0. RAS entry contents are don't-care. Reset overrides trap and every other input.

## Timing
- Latency is one cycle. Inputs are sampled at edge N, and Address/EPC/flags show the new values after edge N.
- PCPlus4, ras_empty and ras_full are combinational from the registers and valid in the same cycle.
- Reset is synchronous only. Deasserting Reset between edges has no effect until the next edge.
- Reset asserted mid-sequence (e.g. during a stall or with RAS full) clears state at that edge. The next cycle starts at RESET_ADDR with ras_empty=1.
- PCWre=0 with no trap: all registers hold their values, and push/pop/eret are discarded rather than queued.

## Test plan
- Reset then sequential: Reset=0 for 1 edge -> Address=0, EPC=0, ras_empty=1. Then PCWre=1, PCSrc=00 for 3 edges -> Address 4, 8, C. PCWre=0 for 2 edges -> Address holds at C.
- Branch/jump modes: Address=0x10, PCSrc=01, immediate=FFFF_FFF8 (−8) -> Address=0x04. PCSrc=10, immediate=0x200 -> 0x200. PCSrc=11, target=0x3000 -> 0x3000. From Address=FFFF_FFFC with PCSrc=00 -> 0.
- RAS call/return: push with PCSrc=10 at Address 0x20 (imm 0x100) -> Address=0x100, top=0x24. pop -> Address=0x24, ras_empty=1. Another pop -> Address=0x28, ras_underflow=1 and sticky until reset.
- RAS overflow (depth 4): 5 pushes at Addresses 0x00, 0x10, 0x20, 0x30, 0x40 -> ras_full=1. 4 pops return 0x44, 0x34, 0x24, 0x14, then ras_empty=1.
- Simultaneous push+pop with top=0x24 at Address 0x50 -> Address=0x24, count unchanged, new top=0x54.
- Trap/eret: trap=1 with PCWre=0 at Address 0x80 -> Address=TRAP_ADDR=0x100, EPC=0x80. eret=1 with PCSrc=10 -> Address=0x80. trap with Reset=0 at the same edge -> Address=0, EPC=0.

Source files
------------

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter with next-PC selection, a circular
//               return-address stack and an exception PC register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_ADDR = '0,
    parameter logic [WIDTH-1:0]   TRAP_ADDR  = 32'h0000_0100,
    parameter int                 IMM_SHIFT  = 1,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             PCWre,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] target,
    input  logic             push,
    input  logic             pop,
    input  logic             trap,
    input  logic             eret,
    output logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] EPC,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);

    localparam int               c_PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] c_FOUR      = WIDTH'(4);

    localparam logic [1:0] c_SRC_SEQ = 2'b00;
    localparam logic [1:0] c_SRC_REL = 2'b01;
    localparam logic [1:0] c_SRC_ABS = 2'b10;
    localparam logic [1:0] c_SRC_REG = 2'b11;

    logic [WIDTH-1:0]   r_address;
    logic [WIDTH-1:0]   r_epc;
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_count;
    logic               r_underflow;
    logic [WIDTH-1:0]   r_ras [RAS_DEPTH];

    logic [WIDTH-1:0]   w_pc_plus4;
    logic [WIDTH-1:0]   w_branch;
    logic [WIDTH-1:0]   w_next_pc;
    logic [c_PTR_W-1:0] w_top_inc;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic               w_adv;
    logic               w_do_pop;
    logic               w_pop_ok;
    logic               w_do_push;
    logic               w_empty;
    logic               w_full;

    assign w_pc_plus4 = r_address + c_FOUR;
    assign w_branch   = w_pc_plus4 + (immediate << IMM_SHIFT);
    assign w_top_inc  = r_top + 1'b1;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH_CNT);

    // Stack side effects only happen on an advancing, non-trap, non-eret cycle.
    assign w_adv     = PCWre & ~trap;
    assign w_do_pop  = w_adv & ~eret & pop;
    assign w_pop_ok  = w_do_pop & ~w_empty;
    assign w_do_push = w_adv & ~eret & push;

    // A combined push+pop overwrites the slot just popped.
    assign w_wr_idx  = w_pop_ok ? r_top : w_top_inc;

    always_comb begin
        w_next_pc = r_address;
        if (trap) begin
            w_next_pc = TRAP_ADDR;
        end else if (PCWre) begin
            if (eret) begin
                w_next_pc = r_epc;
            end else if (pop) begin
                w_next_pc = w_empty ? w_pc_plus4 : r_ras[r_top];
            end else begin
                case (PCSrc)
                    c_SRC_SEQ: w_next_pc = w_pc_plus4;
                    c_SRC_REL: w_next_pc = w_branch;
                    c_SRC_ABS: w_next_pc = immediate;
                    c_SRC_REG: w_next_pc = target;
                    default:   w_next_pc = w_pc_plus4;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_address   <= RESET_ADDR;
            r_epc       <= '0;
            r_top       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_address <= w_next_pc;
            if (trap) begin
                r_epc <= r_address;
            end
            if (w_do_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_pop_ok && !w_do_push) begin
                r_top   <= r_top - 1'b1;
                r_count <= r_count - 1'b1;
            end else if (w_do_push && !w_pop_ok) begin
                r_top <= w_top_inc;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // Entry contents need no reset; only the pointer and count are meaningful.
    always_ff @(posedge clk) begin
        if (Reset && w_do_push) begin
            r_ras[w_wr_idx] <= w_pc_plus4;
        end
    end

    assign Address       = r_address;
    assign PCPlus4       = w_pc_plus4;
    assign EPC           = r_epc;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_underflow = r_underflow;

endmodule

`default_nettype wire
